// File: rtl/daq_register_bank.sv
// Control/status register bank with RW, RO, sticky W1C and self-clearing PULSE kinds; reads take 1 cycle.
// Accesses are always accepted (no backpressure); bad accesses raise a one-cycle err strobe.
module daq_register_bank #(
  parameter int                             DATA_W     = 16,
  parameter int                             ADDR_W     = 5,
  parameter int                             NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]            W1C_MASK   = '0,
  parameter logic [NUM_REGS-1:0]            PULSE_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VAL  = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic                          err,
  input  logic [NUM_REGS*DATA_W-1:0]    status_in,
  output logic [NUM_REGS*DATA_W-1:0]    ctrl_out,
  output logic [NUM_REGS-1:0]           wr_strobe
);

  // Overlapping mask bits resolve as RO > W1C > PULSE > RW.
  localparam logic [NUM_REGS-1:0] IS_RO    = RO_MASK;
  localparam logic [NUM_REGS-1:0] IS_W1C   = W1C_MASK & ~RO_MASK;
  localparam logic [NUM_REGS-1:0] IS_PULSE = PULSE_MASK & ~(RO_MASK | W1C_MASK);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0][DATA_W-1:0] status;
  logic [NUM_REGS-1:0]             wr_hit;
  logic [DATA_W-1:0]               rd_mux;
  logic                            addr_legal;
  logic                            wr_ro;
  logic                            wr_err;
  logic                            unused_bits;

  assign status     = status_in;
  assign addr_legal = {1'b0, addr} < (ADDR_W+1)'(NUM_REGS);
  assign wr_ro      = |(wr_hit & IS_RO);
  assign wr_err     = wr_en & (~addr_legal | wr_ro);

  // Status slices of RW/PULSE registers and the unused storage of RO registers are intentionally dropped.
  assign unused_bits = ^{status_in, regs};

  // Decoding against the current register contents gives read-before-write for free.
  always_comb begin
    wr_hit = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        wr_hit[i] = wr_en;
        rd_mux    = IS_RO[i] ? status[i] : regs[i];
      end
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ctrl_out[i*DATA_W +: DATA_W] = IS_RO[i] ? status[i] : regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (IS_RO[i] | IS_W1C[i] | IS_PULSE[i]) ? '0 : RESET_VAL[i*DATA_W +: DATA_W];
      end
      wr_strobe <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (IS_RO[i]) begin
          regs[i] <= '0;
        end else if (IS_W1C[i]) begin
          // Status sets are OR-ed in after the clear so a coincident set survives.
          regs[i] <= wr_hit[i] ? ((regs[i] & ~wr_data) | status[i]) : (regs[i] | status[i]);
        end else if (IS_PULSE[i]) begin
          regs[i] <= wr_hit[i] ? wr_data : '0;
        end else if (wr_hit[i]) begin
          regs[i] <= wr_data;
        end
      end
      wr_strobe <= wr_hit & ~IS_RO;
      rd_valid  <= rd_en;
      if (rd_en) begin
        rd_data <= addr_legal ? rd_mux : '0;
      end
      err <= wr_err | (rd_en & ~addr_legal);
    end
  end

endmodule

// File: tb/tb_daq_register_bank.sv
// Bench for daq_register_bank: per-cycle compare against a behavioural register model plus literal pins.
module tb_daq_register_bank;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int NR = 16;
  localparam logic [NR*DW-1:0] RV = 256'hBEEF << 32;

  localparam int K_RW = 0, K_RO = 1, K_W1C = 2, K_PULSE = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [AW-1:0]      addr;
  logic               wr_en;
  logic [DW-1:0]      wr_data;
  logic               rd_en;
  logic [DW-1:0]      rd_data;
  logic               rd_valid;
  logic               err;
  logic [NR*DW-1:0]   status_in;
  logic [NR*DW-1:0]   ctrl_out;
  logic [NR-1:0]      wr_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  daq_register_bank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR),
    .RO_MASK(16'h0001), .W1C_MASK(16'h0008), .PULSE_MASK(16'h0080),
    .RESET_VAL(RV)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
    .status_in(status_in), .ctrl_out(ctrl_out), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  // Model: register values and their kinds, updated at each rising edge from the sampled inputs.
  int            kind [NR];
  logic [DW-1:0] m_reg [NR];
  logic [DW-1:0] exp_rd_data;
  logic          exp_rd_valid;
  logic          exp_err;
  logic [NR-1:0] exp_strobe;
  bit            model_live = 0;

  initial begin
    for (int i = 0; i < NR; i++) kind[i] = K_RW;
    kind[0] = K_RO;
    kind[3] = K_W1C;
    kind[7] = K_PULSE;
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) m_reg[i] = (kind[i] == K_RW) ? RV[i*DW +: DW] : '0;
      exp_rd_data  = '0;
      exp_rd_valid = 0;
      exp_err      = 0;
      exp_strobe   = '0;
      model_live   = 1;
    end else if (model_live) begin
      int  a;
      bit  legal;
      a     = int'(addr);
      legal = a < NR;
      exp_rd_valid = rd_en;
      if (rd_en) begin
        if (!legal)               exp_rd_data = '0;
        else if (kind[a] == K_RO) exp_rd_data = status_in[a*DW +: DW];
        else                      exp_rd_data = m_reg[a];
      end
      exp_err = (wr_en && (!legal || kind[a] == K_RO)) || (rd_en && !legal);
      for (int i = 0; i < NR; i++) begin
        bit hit;
        logic [DW-1:0] s;
        hit = wr_en && (a == i);
        s   = status_in[i*DW +: DW];
        exp_strobe[i] = hit && (kind[i] != K_RO);
        case (kind[i])
          K_W1C:   m_reg[i] = hit ? ((m_reg[i] & ~wr_data) | s) : (m_reg[i] | s);
          K_PULSE: m_reg[i] = hit ? wr_data : '0;
          K_RW:    if (hit) m_reg[i] = wr_data;
          default: m_reg[i] = '0;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      logic [NR*DW-1:0] exp_ctrl;
      for (int i = 0; i < NR; i++)
        exp_ctrl[i*DW +: DW] = (kind[i] == K_RO) ? status_in[i*DW +: DW] : m_reg[i];
      chk("ctrl_out", ctrl_out, exp_ctrl);
      chk("wr_strobe", {240'b0, wr_strobe}, {240'b0, exp_strobe});
      chk("rd_valid", {255'b0, rd_valid}, {255'b0, exp_rd_valid});
      chk("err", {255'b0, err}, {255'b0, exp_err});
      if (exp_rd_valid) chk("rd_data", {240'b0, rd_data}, {240'b0, exp_rd_data});
    end
  end

  // Each access task presents its inputs for one rising edge and returns 2 time units after it.
  task automatic idle();
    wr_en = 0; rd_en = 0;
    @(posedge clk); #2;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    addr = AW'(a); wr_data = d; wr_en = 1; rd_en = 0;
    @(posedge clk); #2;
    wr_en = 0;
  endtask

  task automatic rd(input int a);
    addr = AW'(a); rd_en = 1; wr_en = 0;
    @(posedge clk); #2;
    rd_en = 0;
  endtask

  task automatic wrrd(input int a, input logic [DW-1:0] d);
    addr = AW'(a); wr_data = d; wr_en = 1; rd_en = 1;
    @(posedge clk); #2;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk(name, {240'b0, act}, {240'b0, exp});
  endtask

  initial begin
    reset = 1; addr = '0; wr_en = 0; wr_data = '0; rd_en = 0; status_in = '0;
    repeat (2) @(posedge clk);
    #2;
    lit("reset_reg2", ctrl_out[2*DW +: DW], 16'hBEEF);
    lit("reset_strobe", wr_strobe, 16'h0000);
    lit("reset_valid", {15'b0, rd_valid}, 16'h0000);
    reset = 0;

    rd(2);
    lit("rd2_data", rd_data, 16'hBEEF);
    lit("rd2_valid", {15'b0, rd_valid}, 16'h0001);
    lit("rd2_err", {15'b0, err}, 16'h0000);
    idle();
    lit("rd2_valid_drop", {15'b0, rd_valid}, 16'h0000);

    wr(5, 16'h1234);
    lit("wr5_strobe", wr_strobe, 16'h0020);
    idle();
    lit("wr5_strobe_drop", wr_strobe, 16'h0000);
    rd(5);
    lit("rd5_data", rd_data, 16'h1234);

    wrrd(5, 16'h5678);
    lit("rbw_old", rd_data, 16'h1234);
    rd(5);
    lit("rbw_new", rd_data, 16'h5678);

    status_in[3*DW] = 1'b1;
    idle();
    status_in[3*DW] = 1'b0;
    rd(3);
    lit("w1c_set", rd_data, 16'h0001);
    status_in[3*DW] = 1'b1;
    wr(3, 16'h0001);
    status_in[3*DW] = 1'b0;
    rd(3);
    lit("w1c_set_wins", rd_data, 16'h0001);
    wr(3, 16'h0001);
    rd(3);
    lit("w1c_clear", rd_data, 16'h0000);

    wr(7, 16'h0003);
    lit("pulse_hi", ctrl_out[7*DW +: DW], 16'h0003);
    idle();
    lit("pulse_lo", ctrl_out[7*DW +: DW], 16'h0000);
    wr(7, 16'h0009);
    wr(7, 16'h0009);
    lit("pulse_b2b", ctrl_out[7*DW +: DW], 16'h0009);
    idle();
    lit("pulse_b2b_lo", ctrl_out[7*DW +: DW], 16'h0000);

    status_in[0 +: DW] = 16'hA5A5;
    wr(0, 16'hFFFF);
    lit("ro_wr_err", {15'b0, err}, 16'h0001);
    lit("ro_wr_strobe", wr_strobe, 16'h0000);
    idle();
    lit("ro_err_drop", {15'b0, err}, 16'h0000);
    lit("ro_mirror", ctrl_out[0 +: DW], 16'hA5A5);
    rd(0);
    lit("ro_rd", rd_data, 16'hA5A5);
    lit("ro_rd_err", {15'b0, err}, 16'h0000);
    rd(20);
    lit("oor_data", rd_data, 16'h0000);
    lit("oor_valid", {15'b0, rd_valid}, 16'h0001);
    lit("oor_err", {15'b0, err}, 16'h0001);
    wr(17, 16'h4444);
    lit("oor_wr_err", {15'b0, err}, 16'h0001);
    lit("oor_wr_strobe", wr_strobe, 16'h0000);
    idle();

    addr = AW'(5); rd_en = 1; wr_en = 1; wr_data = 16'h7777; reset = 1;
    @(posedge clk); #2;
    rd_en = 0; wr_en = 0; reset = 0;
    lit("rst_rd_valid", {15'b0, rd_valid}, 16'h0000);
    lit("rst_reg5", ctrl_out[5*DW +: DW], 16'h0000);
    lit("rst_reg2", ctrl_out[2*DW +: DW], 16'hBEEF);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
